mem_loader: RTL and testbench
=============================

# mem_loader

Bus initiator that drives the single-port side of the system's byte-wide ROM/RAM from a byte stream, typically fed by a UART receiver. It decodes a small command protocol to load a block of memory (write) or dump one back (read). It sits between the serial link and the memory's `ADDRESS`/`DATA_IN`/`DATA_OUT`/`write_enable`/`output_enable` pins, muxed with the CPU while `busy` is high.

## Interface
- `ADDR_W`, 15: memory address width; addresses wrap modulo 2^ADDR_W.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: command/data byte in.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready` at posedge.
- `tx_data` out 8: response byte out.
- `tx_valid` out 1: `tx_data` valid; held with data stable until accepted.
- `tx_ready` in 1: sink accepts when `tx_valid && tx_ready` at posedge.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data, combinational from `mem_addr` while `mem_oe`.
- `mem_we` out 1: write strobe; memory captures on the following negedge.
- `mem_oe` out 1: read enable.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Commands: `0x57` ('W') = write, `0x52` ('R') = read. Header after opcode: addr_hi, addr_lo, len. Address = {addr_hi, addr_lo}[ADDR_W-1:0]; upper bits are ignored. A len of 0 means 256 bytes.
- States: IDLE → AHI → ALO → LEN → (WDATA | RADDR) … → ACK → CSUM → IDLE; NAK → IDLE.
- IDLE: accept the opcode. On an unknown opcode, go to NAK, which emits `0x15` and then returns to IDLE.
- WDATA:
  - Each accepted byte registers `mem_addr`/`mem_wdata` and pulses `mem_we` for exactly one cycle. The address then increments.
  - After the len-th byte, go to ACK and emit `0x06`.
- RADDR: drive `mem_oe=1` with `mem_addr`. On the next posedge, capture `mem_rdata` into `tx_data`, assert `tx_valid`, and go to RDATA.
- RDATA: on handshake, drop `tx_valid` and increment the address. Return to RADDR while bytes remain; otherwise go to CSUM (macro set) or IDLE.
- Reads emit no ACK.
- `rx_ready` is 1 only in IDLE/AHI/ALO/LEN/WDATA. It is 0 while any response is pending.
- `mem_oe` is 0 outside RADDR. `mem_we` is never high together with `mem_oe`.
- Address increment wraps from 2^ADDR_W-1 to 0 and continues. Len is counted in 9 bits.
- Reset mid-operation: all outputs return to reset values immediately. The partial block is abandoned and no response is sent.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_oe`=0, `busy`=0. `rx_ready` rises on the first posedge after reset release.
- Write throughput is 1 byte/cycle. `mem_we` is high in the cycle after each accept, so a back-to-back stream gives a continuous `mem_we`.
- ACK `tx_valid` rises in the cycle after the last `mem_we` pulse.
- Read: 2 cycles per byte minimum (RADDR, then RDATA with immediate `tx_ready`). Each extra cycle of `tx_ready` low adds one cycle.
- `tx_valid` is held and `tx_data` is stable until the handshake. `tx_ready` low for any duration loses nothing.
- `rx_valid` low mid-block stalls in place, with no timeout.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined:
  - Keep an 8-bit sum mod 256 of all data bytes in the block (bytes written, or bytes read).
  - Writes respond `0x06` then the sum. Reads append the sum after the last data byte.
  - The sum clears on each opcode accept.
- Undefined: the CSUM state and accumulator are absent. Writes respond `0x06` only; reads end after the last data byte.

## Structure
- Package `mem_loader_pkg`: opcode constants (`0x57`, `0x52`), `ACK=0x06`, `NAK=0x15`, and the state enum.
- Single module with no sub-module. The checksum is an inline accumulator under the macro.

## Test plan
- Write `57 01 00 03 AA BB CC` streamed back-to-back:
  - `mem_we` pulses on 3 consecutive cycles at addr 0x0100/0x0101/0x0102 with data AA/BB/CC.
  - tx `06`, plus `31` with the checksum macro.
- Read `52 01 00 03` after the above: tx `AA BB CC` (plus `31` with the macro). Test once with `tx_ready` held low 5 cycles per byte; no duplicates or loss.
- Opcode `0x41`: tx `15`, back in IDLE, no `mem_we`/`mem_oe` activity. A following valid command then succeeds.
- Write `57 7F FF 02 11 22`: writes land at 0x7FFF then 0x0000. Len `00` with 256 bytes gives exactly 256 `mem_we` pulses.
- Assert `reset_n` low after 2 data bytes of a len=4 write: outputs return to reset values immediately, no ACK is sent, and the next command decodes from IDLE.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: protocol bytes and FSM state encoding for mem_loader.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN adds the CSUM state.
package mem_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AHI,
    ST_ALO,
    ST_LEN,
    ST_WDATA,
    ST_RADDR,
    ST_RDATA,
    ST_ACK,
    ST_NAK
`ifdef MEM_LOADER_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte stream in, response stream out and the memory-side bus.
// master = the loader, slave = the UART/memory environment around it.
interface mem_loader_if #(parameter int ADDR_W = 15);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic              mem_oe;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rdata,
    output rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_oe, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rdata,
    input  rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_oe, busy
  );

endinterface

// File: rtl/mem_loader.sv
// mem_loader: decodes 'W'/'R' block commands from a byte stream and drives a
// byte-wide memory. Optional macro MEM_LOADER_CHECKSUM_EN appends an 8-bit
// sum of the block's data bytes to every write and read response.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_loader_if.master bus
);

  state_t            state_reg, state_next;
  logic [7:0]        hi_reg, hi_next;          // latched addr_hi header byte
  logic [ADDR_W-1:0] ptr_reg, ptr_next;        // next write address
  logic [8:0]        cnt_reg, cnt_next;        // bytes remaining (256 fits)
  logic              is_read_reg, is_read_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic              rx_ready_reg, rx_ready_next;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic        rx_accept;
  logic        tx_accept;
  logic [15:0] hdr_addr;

  assign rx_accept = bus.rx_valid && rx_ready_reg;
  assign tx_accept = tx_valid_reg && bus.tx_ready;
  assign hdr_addr  = {hi_reg, bus.rx_data};

  // Next-state and datapath decode; every response state first loads its
  // byte, then holds it until the sink takes it.
  always_comb begin
    state_next    = state_reg;
    hi_next       = hi_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    is_read_next  = is_read_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_next     = csum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (rx_accept) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_next = 8'h00;
`endif
          if (bus.rx_data == OP_WRITE) begin
            is_read_next = 1'b0;
            state_next   = ST_AHI;
          end else if (bus.rx_data == OP_READ) begin
            is_read_next = 1'b1;
            state_next   = ST_AHI;
          end else begin
            state_next   = ST_NAK;
          end
        end
      end
      ST_AHI: begin
        if (rx_accept) begin
          hi_next    = bus.rx_data;
          state_next = ST_ALO;
        end
      end
      ST_ALO: begin
        if (rx_accept) begin
          ptr_next   = ADDR_W'(hdr_addr);
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_accept) begin
          cnt_next = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          if (is_read_reg) begin
            addr_next  = ptr_reg;
            state_next = ST_RADDR;
          end else begin
            state_next = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (rx_accept) begin
          addr_next  = ptr_reg;
          wdata_next = bus.rx_data;
          we_next    = 1'b1;
          ptr_next   = ptr_reg + ADDR_W'(1);
          cnt_next   = cnt_reg - 9'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_next  = csum_reg + bus.rx_data;
`endif
          if (cnt_reg == 9'd1) state_next = ST_ACK;
        end
      end
      ST_RADDR: begin
        tx_data_next  = bus.mem_rdata;
        tx_valid_next = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_next     = csum_reg + bus.mem_rdata;
`endif
        state_next    = ST_RDATA;
      end
      ST_RDATA: begin
        if (tx_accept) begin
          tx_valid_next = 1'b0;
          addr_next     = addr_reg + ADDR_W'(1);
          cnt_next      = cnt_reg - 9'd1;
          if (cnt_reg == 9'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_IDLE;
`endif
          end else begin
            state_next = ST_RADDR;
          end
        end
      end
      ST_ACK: begin
        if (!tx_valid_reg) begin
          tx_data_next  = ACK;
          tx_valid_next = 1'b1;
        end else if (bus.tx_ready) begin
          tx_valid_next = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
          state_next    = ST_CSUM;
`else
          state_next    = ST_IDLE;
`endif
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!tx_valid_reg) begin
          tx_data_next  = csum_reg;
          tx_valid_next = 1'b1;
        end else if (bus.tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end
`endif
      ST_NAK: begin
        if (!tx_valid_reg) begin
          tx_data_next  = NAK;
          tx_valid_next = 1'b1;
        end else if (bus.tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    rx_ready_next = (state_next inside {ST_IDLE, ST_AHI, ST_ALO, ST_LEN, ST_WDATA});
  end

  // State and output registers; reset abandons any partial block silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      hi_reg       <= '0;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      is_read_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      rx_ready_reg <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      hi_reg       <= hi_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      is_read_reg  <= is_read_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      rx_ready_reg <= rx_ready_next;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_valid  = tx_valid_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_we    = we_reg;
  assign bus.mem_oe    = (state_reg == ST_RADDR);
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader. Expected memory writes and
// response bytes are queued as commands are driven and popped as the DUT
// produces them. Honours MEM_LOADER_CHECKSUM_EN for the expected responses.
module tb_mem_loader;

  localparam int ADDR_W = 15;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_loader_if #(.ADDR_W(ADDR_W)) bus();

  mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // environment memory (written by DUT) and reference memory (written by bench)
  logic [7:0] env_mem [0:MEM_SZ-1];
  logic [7:0] ref_mem [0:MEM_SZ-1];
  assign bus.mem_rdata = bus.mem_oe ? env_mem[bus.mem_addr] : 8'h00;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [7:0]        tx_q [$];
  logic [ADDR_W+7:0] wr_q [$];
  logic [7:0]        wbuf [0:255];

  int   cyc        = 0;
  int   we_count   = 0;
  int   oe_count   = 0;
  int   we_first   = 0;
  int   we_last    = 0;
  bit   wr_active  = 1'b0;
  bit   stall_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // memory model + monitor, sampled on the falling edge
  initial begin : monitor
    logic              prev_we;
    logic              prev_tx_valid;
    logic [7:0]        prev_tx_data;
    logic              prev_hs;
    logic              hs;
    logic [ADDR_W+7:0] ew;
    logic [7:0]        et;
    prev_we = 1'b0; prev_tx_valid = 1'b0; prev_tx_data = 8'h00; prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      hs = bus.tx_valid && bus.tx_ready;
      check_eq("we_oe_excl", 32'(bus.mem_we & bus.mem_oe), 32'd0);
      if (bus.mem_oe) oe_count++;
      if (bus.mem_we) begin
        env_mem[bus.mem_addr] = bus.mem_wdata;
        if (we_count == 0) we_first = cyc;
        we_last = cyc;
        we_count++;
        check_eq("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          ew = wr_q.pop_front();
          check_eq("wr_addr", 32'(bus.mem_addr), 32'(ew[ADDR_W+7:8]));
          check_eq("wr_data", 32'(bus.mem_wdata), 32'(ew[7:0]));
        end
      end
      if (wr_active && bus.tx_valid && !prev_tx_valid) begin
        check_eq("ack_after_we", 32'(prev_we), 32'd1);
        wr_active = 1'b0;
      end
      if (prev_tx_valid && !prev_hs) begin
        check_eq("tx_hold", 32'(bus.tx_valid), 32'd1);
        check_eq("tx_stable", 32'(bus.tx_data), 32'(prev_tx_data));
      end
      if (hs) begin
        check_eq("tx_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          et = tx_q.pop_front();
          check_eq("tx_data", 32'(bus.tx_data), 32'(et));
        end
      end
      prev_we       = bus.mem_we;
      prev_tx_valid = bus.tx_valid;
      prev_tx_data  = bus.tx_data;
      prev_hs       = hs;
    end
  end

  // tx_ready driver: always ready, or 5 low cycles per offered byte
  initial begin : tx_sink
    int stall_cnt;
    stall_cnt    = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        bus.tx_ready = 1'b1;
      end else if (!bus.tx_valid) begin
        bus.tx_ready = 1'b0;
        stall_cnt    = 0;
      end else if (stall_cnt < 5) begin
        bus.tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.tx_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int waitc;
    waitc        = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.rx_ready) begin
      check_eq("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (bus.busy || tx_q.size() != 0 || wr_q.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_drain"}, 32'(tx_q.size() + wr_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_write(input logic [15:0] a, input int n);
    logic [ADDR_W-1:0] p;
    logic [7:0]        sum;
    logic [7:0]        len;
    p   = a[ADDR_W-1:0];
    sum = 8'h00;
    len = n[7:0];
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({p, wbuf[i]});
      ref_mem[p] = wbuf[i];
      sum = sum + wbuf[i];
      p   = p + 1'b1;
    end
    tx_q.push_back(8'h06);
`ifdef MEM_LOADER_CHECKSUM_EN
    tx_q.push_back(sum);
`endif
    wr_active = 1'b1;
    send_byte(8'h57);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len);
    for (int i = 0; i < n; i++) send_byte(wbuf[i]);
    bus.rx_valid = 1'b0;
    wait_done("write");
    $display("cmd W addr=0x%04h len=%0d sum=0x%02h done at cycle %0d", a, n, sum, cyc);
  endtask

  task automatic cmd_read(input logic [15:0] a, input int n);
    logic [ADDR_W-1:0] p;
    logic [7:0]        sum;
    logic [7:0]        len;
    p   = a[ADDR_W-1:0];
    sum = 8'h00;
    len = n[7:0];
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(ref_mem[p]);
      sum = sum + ref_mem[p];
      p   = p + 1'b1;
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    tx_q.push_back(sum);
`endif
    send_byte(8'h52);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len);
    bus.rx_valid = 1'b0;
    wait_done("read");
    $display("cmd R addr=0x%04h len=%0d stall=%0d done at cycle %0d", a, n, stall_mode, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
    check_eq({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    check_eq({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    check_eq({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_eq({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check_eq({tag, "_mem_oe"},    32'(bus.mem_oe),    32'd0);
    check_eq({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rx_ready_low"}, 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    check_eq({tag, "_rx_ready_rise"}, 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int mark_we;
    int mark_oe;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset("por");

    // basic write, back-to-back stream
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    we_count = 0;
    cmd_write(16'h0100, 3);
    check_eq("w3_we_count", 32'(we_count), 32'd3);
    check_eq("w3_we_consecutive", 32'(we_last - we_first), 32'd2);

    // read back, immediate and stalled sink
    cmd_read(16'h0100, 3);
    stall_mode = 1'b1;
    cmd_read(16'h0100, 3);
    stall_mode = 1'b0;

    // unknown opcode: NAK with no memory activity, then a good command
    mark_we = we_count;
    mark_oe = oe_count;
    tx_q.push_back(8'h15);
    send_byte(8'h41);
    bus.rx_valid = 1'b0;
    wait_done("nak");
    check_eq("nak_no_we", 32'(we_count - mark_we), 32'd0);
    check_eq("nak_no_oe", 32'(oe_count - mark_oe), 32'd0);
    $display("cmd 0x41 -> NAK done at cycle %0d", cyc);
    cmd_read(16'h0100, 3);

    // address wrap at the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    cmd_write(16'h7FFF, 2);
    cmd_read(16'h7FFF, 2);

    // len 0 = 256 bytes
    for (int i = 0; i < 256; i++) wbuf[i] = 8'(i) ^ 8'h5A;
    we_count = 0;
    cmd_write(16'h1000, 256);
    check_eq("w256_we_count", 32'(we_count), 32'd256);
    cmd_read(16'h1000, 256);

    // reset after 2 of 4 data bytes
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    wr_q.push_back({15'h0200, 8'h3C});
    wr_q.push_back({15'h0201, 8'hC3});
    ref_mem[15'h0200] = 8'h3C;
    ref_mem[15'h0201] = 8'hC3;
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h3C);
    send_byte(8'hC3);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_eq("midrst_no_ack", 32'(bus.tx_valid), 32'd0);
    check_eq("midrst_wr_drained", 32'(wr_q.size()), 32'd0);
    release_reset("midrst");
    $display("cmd W addr=0x0200 len=4 aborted by reset at cycle %0d", cyc);
    cmd_read(16'h0200, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
